mc_pad_bank_ctrl: RTL and testbench
===================================

// Module: mc_pad_bank_ctrl
// PURPOSE
//   Core-side controller for a bank of NumPads bidirectional pad cells (mc_pad_io-class).
//   Per channel: registered output path, run-time mode, OE turnaround delay,
//   2-flop input synchroniser, optional glitch filter and rising-edge flag.
//   Sits between SoC peripherals/GPIO and the pad ring; one instance per pad bank.
// PARAMETERS
//   NumPads     4  number of pad channels (>=1)
//   TurnCycles  2  cycles OE request must hold before pad_oe_o asserts (>=0; 0 = next cycle)
//   FiltCycles  3  consecutive equal synced samples needed to accept a new input value (>=1)
//   IdxW        $clog2(NumPads) (min 1)  width of cfg_idx_i (derived; not overridden)
// PORTS
//   clk_i          in   1        clock
//   rst_i          in   1        asynchronous reset, active-high
//   cfg_we_i       in   1        config write strobe, one channel per cycle
//   cfg_idx_i      in   IdxW     channel written
//   cfg_mode_i     in   2        00 IN, 01 OUT, 10 BIDIR, 11 OFF
//   cfg_filt_en_i  in   1        enable glitch filter for channel
//   core_d_i       in   NumPads  output data from core
//   core_oe_i      in   NumPads  output-enable request from core (used in BIDIR only)
//   core_d_o       out  NumPads  filtered/synced pad input to core
//   core_rise_o    out  NumPads  1-cycle pulse on accepted 0->1 of core_d_o
//   pad_d_o        out  NumPads  to pad DIN
//   pad_oe_o       out  NumPads  to pad (active-high; pad wrapper inverts to OEN)
//   pad_d_i        in   NumPads  from pad DOUT (asynchronous)
//   busy_o         out  1        OR over channels in state WAIT
// BEHAVIOUR
//   Reset: all modes IN, filt_en 0, FSMs IDLE, counters 0, sync flops 0;
//     all outputs 0. Reset mid-operation drops pad_oe_o to 0 in the same cycle (async).
//   Config: cfg_we_i=1 writes mode/filt_en of cfg_idx_i at clock edge; new value
//     effective next cycle. cfg_idx_i >= NumPads: write ignored, no side effect.
//   Drive request req[n]: IN->0, OUT->1, BIDIR->core_oe_i[n], OFF->0.
//   Output data: pad_d_o[n] <= core_d_i[n] every cycle (1-cycle latency), independent of OE;
//     forced 0 in OFF.
//   OE FSM per channel, states IDLE/WAIT/DRIVE; pad_oe_o[n]=1 only in DRIVE:
//     IDLE : req=1 -> WAIT, cnt<=0 (TurnCycles=0: -> DRIVE directly).
//     WAIT : req=0 -> IDLE (abort); else cnt==TurnCycles-1 -> DRIVE; else cnt++.
//     DRIVE: req=0 -> IDLE (pad_oe_o low the cycle after req falls; release is never delayed).
//     OE rise latency = TurnCycles+1 cycles from req rise; fall latency = 1 cycle.
//     Mode change during WAIT/DRIVE to non-driving mode behaves as req=0.
//   Input path: s1<=pad_d_i, s2<=s1 (2-flop sync, all modes).
//     filt_en=0: core_d_o <= s2 (3 cycles pad->core).
//     filt_en=1: fcnt counts cycles with s2 != core_d_o; reset to 0 when s2==core_d_o;
//       on reaching FiltCycles, core_d_o <= s2 and fcnt <= 0. fcnt width $clog2(FiltCycles+1),
//       never wraps. Toggling filt_en clears fcnt.
//     OFF: core_d_o forced 0, fcnt held 0, no rise pulses.
//   core_rise_o[n]=1 for exactly one cycle after core_d_o[n] changes 0->1 (registered).
//   Channels are fully independent; simultaneous cfg write and req change on one channel:
//     FSM uses old mode this cycle, new mode next cycle.
// TESTING (NumPads=4, TurnCycles=2, FiltCycles=3)
//   Reset released, pad_d_i=4'hF held -> core_d_o=4'hF at cycle 3, core_rise_o=4'hF at cycle 4 only; pad_oe_o=0.
//   Write ch1 OUT -> pad_oe_o[1] rises 3 cycles after mode effective, busy_o=1 meanwhile; core_d_i[1]
//     toggle seen on pad_d_o[1] 1 cycle later.
//   ch2 BIDIR, core_oe_i[2] pulse 2 cycles -> pad_oe_o[2] never asserts (abort); 5-cycle pulse -> asserts 3 cycles.
//   ch0 filt_en=1, pad_d_i[0] glitch high 2 cycles -> core_d_o[0] stays 0; high 3+ cycles -> rises 5 cycles after edge.
//   ch3 DRIVE, assert rst_i mid-cycle -> pad_oe_o[3]=0 immediately; cfg write idx 3 with mode OFF -> core_d_o[3]=0.
//   cfg write with idx 3 OUT while ch3 in WAIT of BIDIR, then OFF -> FSM to IDLE, pad_oe_o stays 0.

Source files
------------

// File: rtl/mc_pad_bank_ctrl.sv
// mc_pad_bank_ctrl: core-side controller for one bank of bidirectional pads.
// Per channel: registered output path, mode, OE turnaround, input sync/filter.
module mc_pad_bank_ctrl #(
    parameter int  NumPads    = 4,
    parameter int  TurnCycles = 2,
    parameter int  FiltCycles = 3,
    localparam int IdxW       = (NumPads > 1) ? $clog2(NumPads) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_we_i,
    input  logic [IdxW-1:0]    cfg_idx_i,
    input  logic [1:0]         cfg_mode_i,
    input  logic               cfg_filt_en_i,
    input  logic [NumPads-1:0] core_d_i,
    input  logic [NumPads-1:0] core_oe_i,
    output logic [NumPads-1:0] core_d_o,
    output logic [NumPads-1:0] core_rise_o,
    output logic [NumPads-1:0] pad_d_o,
    output logic [NumPads-1:0] pad_oe_o,
    input  logic [NumPads-1:0] pad_d_i,
    output logic               busy_o
);

    localparam int CntW = (TurnCycles > 1) ? $clog2(TurnCycles) : 1;
    localparam int FcW  = $clog2(FiltCycles + 1);

    localparam logic [CntW-1:0] TurnLast =
        CntW'((TurnCycles > 0) ? TurnCycles - 1 : 0);
    localparam logic [FcW-1:0]  FiltLast = FcW'(FiltCycles - 1);

    typedef enum logic [1:0] {
        MODE_IN    = 2'b00,
        MODE_OUT   = 2'b01,
        MODE_BIDIR = 2'b10,
        MODE_OFF   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DRIVE
    } oe_state_e;

    logic [NumPads-1:0] waiting;

    for (genvar n = 0; n < NumPads; n++) begin : g_ch
        mode_e           mode_q;
        logic            filt_q;
        logic            cfg_hit;
        logic            filt_toggle;
        logic            req;
        oe_state_e       st_q;
        logic [CntW-1:0] cnt_q;
        logic            oe_q;
        logic            dout_q;
        logic            s1_q;
        logic            s2_q;
        logic            cd_q;
        logic            cd_d1_q;
        logic            rise_q;
        logic [FcW-1:0]  fcnt_q;

        assign cfg_hit     = cfg_we_i && (cfg_idx_i == IdxW'(n));
        assign filt_toggle = cfg_hit && (cfg_filt_en_i != filt_q);

        // Drive request decoded from the currently effective mode
        always_comb begin
            req = 1'b0;
            unique case (mode_q)
                MODE_IN:    req = 1'b0;
                MODE_OUT:   req = 1'b1;
                MODE_BIDIR: req = core_oe_i[n];
                MODE_OFF:   req = 1'b0;
                default:    req = 1'b0;
            endcase
        end

        // Channel configuration, takes effect the cycle after the write
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                mode_q <= MODE_IN;
                filt_q <= 1'b0;
            end else if (cfg_hit) begin
                mode_q <= mode_e'(cfg_mode_i);
                filt_q <= cfg_filt_en_i;
            end
        end

        // OE turnaround FSM: delayed assertion, immediate release
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                st_q  <= ST_IDLE;
                cnt_q <= '0;
                oe_q  <= 1'b0;
            end else begin
                unique case (st_q)
                    ST_IDLE: begin
                        cnt_q <= '0;
                        if (req) begin
                            if (TurnCycles == 0) begin
                                st_q <= ST_DRIVE;
                                oe_q <= 1'b1;
                            end else begin
                                st_q <= ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (!req) begin
                            st_q  <= ST_IDLE;
                            cnt_q <= '0;
                        end else if (cnt_q == TurnLast) begin
                            st_q  <= ST_DRIVE;
                            oe_q  <= 1'b1;
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    ST_DRIVE: begin
                        if (!req) begin
                            st_q <= ST_IDLE;
                            oe_q <= 1'b0;
                        end
                    end
                    default: begin
                        st_q  <= ST_IDLE;
                        cnt_q <= '0;
                        oe_q  <= 1'b0;
                    end
                endcase
            end
        end

        // Output data register, held low while the channel is off
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                dout_q <= 1'b0;
            end else begin
                dout_q <= core_d_i[n] && (mode_q != MODE_OFF);
            end
        end

        // Two-flop synchroniser for the asynchronous pad input
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
            end else begin
                s1_q <= pad_d_i[n];
                s2_q <= s1_q;
            end
        end

        // Glitch filter: accept a new level after FiltCycles stable samples
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cd_q   <= 1'b0;
                fcnt_q <= '0;
            end else begin
                if (mode_q == MODE_OFF) begin
                    cd_q   <= 1'b0;
                    fcnt_q <= '0;
                end else if (!filt_q) begin
                    cd_q   <= s2_q;
                    fcnt_q <= '0;
                end else if (s2_q != cd_q) begin
                    if (fcnt_q == FiltLast) begin
                        cd_q   <= s2_q;
                        fcnt_q <= '0;
                    end else begin
                        fcnt_q <= fcnt_q + FcW'(1);
                    end
                end else begin
                    fcnt_q <= '0;
                end
                if (filt_toggle) begin
                    fcnt_q <= '0;
                end
            end
        end

        // Registered rising-edge flag on the accepted input level
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cd_d1_q <= 1'b0;
                rise_q  <= 1'b0;
            end else begin
                cd_d1_q <= cd_q;
                rise_q  <= cd_q && !cd_d1_q && (mode_q != MODE_OFF);
            end
        end

        assign pad_oe_o[n]    = oe_q;
        assign pad_d_o[n]     = dout_q;
        assign core_d_o[n]    = cd_q;
        assign core_rise_o[n] = rise_q;
        assign waiting[n]     = (st_q == ST_WAIT);
    end

    assign busy_o = |waiting;

endmodule

// File: tb/tb_mc_pad_bank_ctrl.sv
// tb_mc_pad_bank_ctrl: vector table, corner sequences and a randomized
// run against a history-based reference model of the pad bank.
module tb_mc_pad_bank_ctrl;

    localparam int NP = 4;
    localparam int TC = 2;
    localparam int FC = 3;
    localparam int NR = 1500;
    localparam int NV = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [1:0]    cfg_idx;
    logic [1:0]    cfg_mode;
    logic          cfg_filt;
    logic [NP-1:0] core_d_in;
    logic [NP-1:0] core_oe;
    logic [NP-1:0] core_d_out;
    logic [NP-1:0] core_rise;
    logic [NP-1:0] pad_d_out;
    logic [NP-1:0] pad_oe;
    logic [NP-1:0] pad_d_in;
    logic          busy;

    mc_pad_bank_ctrl #(
        .NumPads(NP),
        .TurnCycles(TC),
        .FiltCycles(FC)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .cfg_we_i(cfg_we),
        .cfg_idx_i(cfg_idx),
        .cfg_mode_i(cfg_mode),
        .cfg_filt_en_i(cfg_filt),
        .core_d_i(core_d_in),
        .core_oe_i(core_oe),
        .core_d_o(core_d_out),
        .core_rise_o(core_rise),
        .pad_d_o(pad_d_out),
        .pad_oe_o(pad_oe),
        .pad_d_i(pad_d_in),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [1:0] idx;
        logic [1:0] mode;
        logic [3:0] cd;
        logic [3:0] pd;
        logic [3:0] e_oe;
        logic [3:0] e_dout;
        logic [3:0] e_cdo;
        logic [3:0] e_rise;
        logic       e_busy;
    } vec_t;

    vec_t tbl [NV];

    int n_vec = 0;
    int n_bad = 0;

    logic [3:0] ph [0:NR];
    logic [3:0] sh [0:NR];
    logic [3:0] oh [0:NR];
    int         clr [NP];
    int         run [NP];
    logic [1:0] mm  [NP];
    logic       mf  [NP];

    function automatic vec_t mk(input logic we, input logic [1:0] idx,
                                input logic [1:0] mode, input logic [3:0] cd,
                                input logic [3:0] pd, input logic [3:0] e_oe,
                                input logic [3:0] e_dout, input logic [3:0] e_cdo,
                                input logic [3:0] e_rise, input logic e_busy);
        vec_t v;
        v.we = we; v.idx = idx; v.mode = mode; v.cd = cd; v.pd = pd;
        v.e_oe = e_oe; v.e_dout = e_dout; v.e_cdo = e_cdo;
        v.e_rise = e_rise; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] outs();
        return {15'd0, pad_oe, pad_d_out, core_d_out, core_rise, busy};
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_mode  = '0;
        cfg_filt  = 1'b0;
        core_d_in = '0;
        core_oe   = '0;
        pad_d_in  = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", outs(), 32'd0);
        rst = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] idx, input logic [1:0] mode,
                       input logic filt);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_mode = mode;
        cfg_filt = filt;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        int         hits;
        int         lat;
        logic [8:0] pat;
        logic [8:0] pexp;
        logic [3:0] e_oe, e_dout, e_cdo, e_rise;
        logic       e_busy;

        tbl[0]  = mk(0, 0, 0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        tbl[1]  = mk(0, 0, 0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        tbl[2]  = mk(0, 0, 0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 0);
        tbl[3]  = mk(1, 1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 0);
        tbl[4]  = mk(0, 0, 0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 1);
        tbl[5]  = mk(0, 0, 0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 1);
        tbl[6]  = mk(0, 0, 0, 4'h2, 4'hF, 4'h2, 4'h2, 4'hF, 4'h0, 0);
        tbl[7]  = mk(0, 0, 0, 4'h0, 4'hF, 4'h2, 4'h0, 4'hF, 4'h0, 0);
        tbl[8]  = mk(1, 1, 0, 4'h2, 4'hF, 4'h2, 4'h2, 4'hF, 4'h0, 0);
        tbl[9]  = mk(0, 0, 0, 4'h2, 4'hF, 4'h0, 4'h2, 4'hF, 4'h0, 0);
        tbl[10] = mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 0);
        tbl[11] = mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 0);
        tbl[12] = mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        tbl[13] = mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);

        // Vector table from reset release
        do_reset();
        for (int i = 0; i < NV; i++) begin
            cfg_we    = tbl[i].we;
            cfg_idx   = tbl[i].idx;
            cfg_mode  = tbl[i].mode;
            cfg_filt  = 1'b0;
            core_d_in = tbl[i].cd;
            core_oe   = '0;
            pad_d_in  = tbl[i].pd;
            tick();
            chk($sformatf("vec%0d", i), outs(),
                {15'd0, tbl[i].e_oe, tbl[i].e_dout, tbl[i].e_cdo,
                 tbl[i].e_rise, tbl[i].e_busy});
        end
        cfg_we = 1'b0;

        // BIDIR: short request aborts, long request drives
        do_reset();
        cfg(2'd2, 2'd2, 1'b0);
        hits = 0;
        core_oe = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) core_oe = 4'b0000;
            tick();
            if (i == 0) chk("bidir_wait_busy", {31'd0, busy}, 32'd1);
            if (pad_oe[2]) hits++;
        end
        chk("bidir_abort", hits, 0);
        core_oe = 4'b0100;
        for (int i = 0; i < 9; i++) begin
            if (i == 5) core_oe = 4'b0000;
            tick();
            pat[i]  = pad_oe[2];
            pexp[i] = (i >= TC) && (i < 5);
        end
        chk("bidir_pulse5", {23'd0, pat}, {23'd0, pexp});

        // Glitch filter on ch0
        do_reset();
        cfg(2'd0, 2'd0, 1'b1);
        repeat (3) tick();
        hits = 0;
        pad_d_in = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) pad_d_in = 4'b0000;
            tick();
            if (core_d_out[0]) hits++;
        end
        chk("filt_glitch2", hits, 0);
        pad_d_in = 4'b0001;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (core_d_out[0] && lat == 0) lat = i;
        end
        chk("filt_latency", lat, FC + 2);
        pad_d_in = 4'b0000;
        do_reset();
        cfg(2'd0, 2'd0, 1'b1);
        pad_d_in = 4'b0001;
        for (int i = 1; i <= FC + 2; i++) tick();
        chk("filt_accept", {28'd0, core_d_out}, 32'h1);
        tick();
        chk("filt_rise", {28'd0, core_rise}, 32'h1);

        // ch3 DRIVE, async reset, then OFF forces input low
        do_reset();
        cfg(2'd3, 2'd1, 1'b0);
        repeat (TC + 1) tick();
        chk("ch3_drive", {28'd0, pad_oe}, 32'h8);
        #2 rst = 1'b1;
        #1 chk("async_rst_oe", {28'd0, pad_oe}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        pad_d_in  = 4'b1000;
        core_d_in = 4'hF;
        repeat (4) tick();
        chk("ch3_in_high", {28'd0, core_d_out}, 32'h8);
        cfg(2'd3, 2'd3, 1'b0);
        tick();
        chk("ch3_off_cdo", {28'd0, core_d_out}, 32'h0);
        chk("ch3_off_dout", {28'd0, pad_d_out}, 32'h7);
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (core_d_out[3] || core_rise[3]) hits++;
        end
        chk("ch3_off_hold", hits, 0);

        // BIDIR WAIT, rewritten to OUT then OFF: never drives
        do_reset();
        cfg(2'd3, 2'd2, 1'b0);
        core_oe  = 4'b1000;
        cfg(2'd3, 2'd1, 1'b0);
        chk("wait_busy", {31'd0, busy}, 32'd1);
        cfg(2'd3, 2'd3, 1'b0);
        chk("wait_busy2", {28'd0, pad_oe, 3'd0, busy}, 32'd1);
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pad_oe[3]) hits++;
            if (i == 0) chk("wait_idle", {31'd0, busy}, 32'd0);
        end
        chk("wait_off_no_oe", hits, 0);

        // Randomized run against the reference model
        do_reset();
        for (int n = 0; n < NP; n++) begin
            clr[n] = 0; run[n] = 0; mm[n] = 2'd0; mf[n] = 1'b0;
        end
        ph[0] = '0; sh[0] = '0; oh[0] = '0;
        for (int k = 1; k <= NR; k++) begin
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_idx   = 2'($urandom_range(0, 3));
            cfg_mode  = 2'($urandom_range(0, 3));
            cfg_filt  = 1'($urandom_range(0, 1));
            core_d_in = 4'($urandom);
            for (int n = 0; n < NP; n++) begin
                if ($urandom_range(0, 5) == 0) core_oe[n] = ~core_oe[n];
                if ($urandom_range(0, 2) == 0) pad_d_in[n] = ~pad_d_in[n];
            end
            ph[k] = pad_d_in;
            e_oe = '0; e_dout = '0; e_cdo = '0; e_rise = '0; e_busy = 1'b0;
            for (int n = 0; n < NP; n++) begin
                logic req, samp, prev, cur, all_diff, o2;
                req = (mm[n] == 2'd1) || (mm[n] == 2'd2 && core_oe[n]);
                run[n] = req ? run[n] + 1 : 0;
                e_oe[n] = (run[n] > TC);
                if (run[n] >= 1 && run[n] <= TC) e_busy = 1'b1;
                e_dout[n] = core_d_in[n] && (mm[n] != 2'd3);
                samp = (k >= 3) ? ph[k-2][n] : 1'b0;
                sh[k][n] = samp;
                prev = oh[k-1][n];
                cur = prev;
                if (mm[n] == 2'd3) begin
                    cur = 1'b0;
                    clr[n] = k;
                end else if (!mf[n]) begin
                    cur = samp;
                    clr[n] = k;
                end else if (k - clr[n] >= FC) begin
                    all_diff = 1'b1;
                    for (int j = k - FC + 1; j <= k; j++)
                        if (sh[j][n] == prev) all_diff = 1'b0;
                    if (all_diff) begin
                        cur = samp;
                        clr[n] = k;
                    end
                end
                oh[k][n] = cur;
                e_cdo[n] = cur;
                o2 = (k >= 2) ? oh[k-2][n] : 1'b0;
                e_rise[n] = prev && !o2 && (mm[n] != 2'd3);
                if (cfg_we && cfg_idx == 2'(n)) begin
                    if (cfg_filt != mf[n]) clr[n] = k;
                    mm[n] = cfg_mode;
                    mf[n] = cfg_filt;
                end
            end
            tick();
            chk($sformatf("rnd%0d", k), outs(),
                {15'd0, e_oe, e_dout, e_cdo, e_rise, e_busy});
        end
        cfg_we = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
